// File: rtl/gcd_pkg.sv
// Shared definitions for the gcd engine, its requester and their benches.
package gcd_pkg;

    localparam int GCD_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ERROR = 2'd3
    } gcd_state_e;

endpackage

// File: rtl/gcd_op_fifo.sv
// Synchronous FIFO of {a,b} operand pairs feeding the gcd requester.
module gcd_op_fifo
    import gcd_pkg::*;
#(
    parameter int DATA_W = GCD_DATA_W,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_push,
    input  logic [2*DATA_W-1:0]   i_data,
    input  logic                  i_pop,
    output logic [2*DATA_W-1:0]   o_data,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [CW-1:0]         o_count
);

    logic [2*DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wr_ptr;
    logic [AW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                w_push;
    logic                w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_data  = r_mem[r_rd_ptr];

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/gcd_client.sv
// Requester for the gcd engine: buffers operand pairs, issues starts,
// captures results and flags an engine that never answers.
module gcd_client
    import gcd_pkg::*;
#(
    parameter int DATA_W     = GCD_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 4096,
    localparam int CW        = $clog2(FIFO_DEPTH + 1),
    localparam int PW        = CW + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_a_i,
    input  logic [DATA_W-1:0] in_b_i,
    output logic              eng_start_o,
    output logic [DATA_W-1:0] eng_a_o,
    output logic [DATA_W-1:0] eng_b_o,
    input  logic              eng_valid_i,
    input  logic [DATA_W-1:0] eng_result_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_result_o,
    output logic              out_timeout_o,
    output logic [PW-1:0]     pending_o
);

    localparam int WD_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int WD_LIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam bit WD_EN  = (TIMEOUT != 0);

    gcd_state_e          r_state;
    logic [WD_W-1:0]     r_wd;
    logic [DATA_W-1:0]   r_eng_a;
    logic [DATA_W-1:0]   r_eng_b;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_result;
    logic                r_out_timeout;

    logic [2*DATA_W-1:0] w_head;
    logic [DATA_W-1:0]   w_head_a;
    logic [DATA_W-1:0]   w_head_b;
    logic                w_full;
    logic                w_empty;
    logic [CW-1:0]       w_count;
    logic                w_push;
    logic                w_pop;
    logic                w_issue;
    logic                w_timeout;

    assign w_issue   = (r_state == ISSUE);
    assign w_push    = in_valid_i & in_ready_o;
    assign w_pop     = w_issue;
    assign w_head_a  = w_head[2*DATA_W-1:DATA_W];
    assign w_head_b  = w_head[DATA_W-1:0];
    assign w_timeout = WD_EN && (r_wd == WD_W'(WD_LIM));

    gcd_op_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .i_push  (w_push),
        .i_data  ({in_a_i, in_b_i}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign in_ready_o    = ~w_full & (r_state != ERROR);
    assign eng_start_o   = w_issue;
    // The engine samples operands in the start cycle, so bypass the regs.
    assign eng_a_o       = w_issue ? w_head_a : r_eng_a;
    assign eng_b_o       = w_issue ? w_head_b : r_eng_b;
    assign out_valid_o   = r_out_valid;
    assign out_result_o  = r_out_result;
    assign out_timeout_o = r_out_timeout;
    assign pending_o     = PW'(w_count) + PW'(r_state == WAIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state       <= IDLE;
            r_wd          <= '0;
            r_eng_a       <= '0;
            r_eng_b       <= '0;
            r_out_valid   <= 1'b0;
            r_out_result  <= '0;
            r_out_timeout <= 1'b0;
        end else begin
            if (r_out_valid && out_ready_i) begin
                r_out_valid <= 1'b0;
            end
            unique case (r_state)
                IDLE: begin
                    if (!w_empty && !r_out_valid) begin
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_eng_a <= w_head_a;
                    r_eng_b <= w_head_b;
                    r_wd    <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (r_wd != '1) begin
                        r_wd <= r_wd + 1'b1;
                    end
                    // A result landing on the deadline still counts.
                    if (eng_valid_i) begin
                        r_out_result  <= eng_result_i;
                        r_out_timeout <= 1'b0;
                        r_out_valid   <= 1'b1;
                        r_state       <= IDLE;
                    end else if (w_timeout) begin
                        r_out_result  <= '0;
                        r_out_timeout <= 1'b1;
                        r_out_valid   <= 1'b1;
                        r_state       <= ERROR;
                    end
                end
                ERROR: begin
                    r_state <= ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gcd_client.sv
// Directed bench for gcd_client with a latency-programmable engine stub.
module tb_gcd_client;

    logic        clk_i;
    logic        rst_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_a_i;
    logic [31:0] in_b_i;
    logic        eng_start_o;
    logic [31:0] eng_a_o;
    logic [31:0] eng_b_o;
    logic        eng_valid_i;
    logic [31:0] eng_result_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_result_o;
    logic        out_timeout_o;
    logic [3:0]  pending_o;

    int n_vec = 0;
    int n_err = 0;
    int n_start = 0;
    int lat = 3;
    int s0;
    int cyc;

    logic        r_stub_valid;
    logic [31:0] r_stub_res;
    logic [31:0] r_sa;
    logic [31:0] r_sb;
    int          r_cnt;
    logic        man_valid;
    logic [31:0] man_res;

    gcd_client #(
        .DATA_W     (32),
        .FIFO_DEPTH (4),
        .TIMEOUT    (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_a_i        (in_a_i),
        .in_b_i        (in_b_i),
        .eng_start_o   (eng_start_o),
        .eng_a_o       (eng_a_o),
        .eng_b_o       (eng_b_o),
        .eng_valid_i   (eng_valid_i),
        .eng_result_i  (eng_result_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_result_o  (out_result_o),
        .out_timeout_o (out_timeout_o),
        .pending_o     (pending_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    function automatic logic [31:0] gcd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Engine stub: valid pulse lat cycles after the start edge; lat=0 never answers.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stub_valid <= 1'b0;
            r_stub_res   <= '0;
            r_cnt        <= 0;
            r_sa         <= '0;
            r_sb         <= '0;
        end else begin
            r_stub_valid <= 1'b0;
            if (eng_start_o) begin
                r_cnt <= 1;
                r_sa  <= eng_a_o;
                r_sb  <= eng_b_o;
            end else if (r_cnt != 0) begin
                if (lat != 0 && r_cnt == lat) begin
                    r_stub_valid <= 1'b1;
                    r_stub_res   <= gcd(r_sa, r_sb);
                    r_cnt        <= 0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    assign eng_valid_i  = r_stub_valid | man_valid;
    assign eng_result_i = man_valid ? man_res : r_stub_res;

    always @(posedge clk_i) begin
        if (eng_start_o) n_start++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b);
        logic ok;
        ok = 1'b0;
        in_valid_i = 1'b1;
        in_a_i = a;
        in_b_i = b;
        for (int k = 0; k < 60; k++) begin
            if (in_ready_o) begin
                @(posedge clk_i);
                @(negedge clk_i);
                ok = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        in_valid_i = 1'b0;
        chk("push_accepted", ok, 1);
    endtask

    task automatic wait_start(input string tag, input logic [31:0] ea, input logic [31:0] eb);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (eng_start_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        chk({tag, "_start"}, seen, 1);
        chk({tag, "_eng_a"}, eng_a_o, ea);
        chk({tag, "_eng_b"}, eng_b_o, eb);
    endtask

    task automatic wait_out(input string tag, input logic [31:0] res, input logic to);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (out_valid_o) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk_i);
        end
        chk({tag, "_valid"}, seen, 1);
        chk({tag, "_result"}, out_result_o, res);
        chk({tag, "_timeout"}, out_timeout_o, to);
        if (out_ready_i) @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b1;
        in_valid_i = 1'b0;
        in_a_i = '0;
        in_b_i = '0;
        out_ready_i = 1'b0;
        man_valid = 1'b0;
        man_res = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_start", eng_start_o, 0);
        chk("rst_eng_a", eng_a_o, 0);
        chk("rst_eng_b", eng_b_o, 0);
        chk("rst_out_valid", out_valid_o, 0);
        chk("rst_result", out_result_o, 0);
        chk("rst_timeout", out_timeout_o, 0);
        chk("rst_pending", pending_o, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("rst_in_ready", in_ready_o, 1);

        // single pair
        out_ready_i = 1'b1;
        s0 = n_start;
        push(48, 18);
        wait_start("t1", 48, 18);
        @(negedge clk_i);
        chk("t1_start_1cyc", eng_start_o, 0);
        chk("t1_pending_wait", pending_o, 1);
        chk("t1_hold_a", eng_a_o, 48);
        wait_out("t1", 6, 0);
        chk("t1_pending_end", pending_o, 0);
        chk("t1_starts", n_start - s0, 1);

        // zero operands
        s0 = n_start;
        push(0, 7);
        push(9, 0);
        wait_out("z1", 7, 0);
        wait_out("z2", 9, 0);
        chk("z_starts", n_start - s0, 2);

        // backpressure
        out_ready_i = 1'b0;
        s0 = n_start;
        push(12, 8);
        push(7, 13);
        push(100, 75);
        push(64, 16);
        push(27, 18);
        repeat (20) @(negedge clk_i);
        chk("bp_valid", out_valid_o, 1);
        chk("bp_result", out_result_o, 4);
        chk("bp_in_ready", in_ready_o, 0);
        chk("bp_pending", pending_o, 4);
        chk("bp_starts", n_start - s0, 1);
        in_valid_i = 1'b1;
        in_a_i = 1;
        in_b_i = 1;
        repeat (5) @(negedge clk_i);
        chk("bp_stall_ready", in_ready_o, 0);
        chk("bp_stall_starts", n_start - s0, 1);
        chk("bp_stall_result", out_result_o, 4);
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        wait_out("bp1", 4, 0);
        wait_out("bp2", 1, 0);
        wait_out("bp3", 25, 0);
        wait_out("bp4", 16, 0);
        wait_out("bp5", 9, 0);
        chk("bp_total_starts", n_start - s0, 5);

        // valid lands in the last watchdog cycle
        lat = 15;
        push(35, 10);
        wait_out("race", 5, 0);
        chk("race_in_ready", in_ready_o, 1);
        lat = 3;
        push(48, 18);
        wait_out("race_next", 6, 0);

        // watchdog timeout
        lat = 0;
        push(1, 1);
        wait_start("to", 1, 1);
        cyc = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            cyc++;
            if (out_valid_o) break;
        end
        chk("to_latency", cyc, 17);
        chk("to_valid", out_valid_o, 1);
        chk("to_result", out_result_o, 0);
        chk("to_flag", out_timeout_o, 1);
        @(negedge clk_i);
        chk("to_handoff", out_valid_o, 0);
        chk("to_in_ready", in_ready_o, 0);
        s0 = n_start;
        man_res = 77;
        man_valid = 1'b1;
        @(negedge clk_i);
        man_valid = 1'b0;
        repeat (3) @(negedge clk_i);
        chk("to_late_valid", out_valid_o, 0);
        chk("to_late_result", out_result_o, 0);
        chk("to_no_start", n_start - s0, 0);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("to_rst_ready", in_ready_o, 1);
        chk("to_rst_flag", out_timeout_o, 0);

        // reset while waiting on the engine
        lat = 0;
        s0 = n_start;
        push(48, 18);
        wait_start("mr", 48, 18);
        repeat (3) @(negedge clk_i);
        chk("mr_pending_wait", pending_o, 1);
        #2 rst_i = 1'b1;
        #1;
        chk("mr_pending", pending_o, 0);
        chk("mr_eng_a", eng_a_o, 0);
        chk("mr_eng_b", eng_b_o, 0);
        chk("mr_out_valid", out_valid_o, 0);
        chk("mr_in_ready", in_ready_o, 1);
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (25) @(negedge clk_i);
        chk("mr_no_result", out_valid_o, 0);
        chk("mr_starts", n_start - s0, 1);
        chk("mr_pending_end", pending_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
